// File: rtl/loader_pkg.sv
// loader_pkg
//   Shared definitions for the UART program loader:
//   - loader FSM state encoding
//   - frame-field constants (sync byte, word size)
//   - a helper that says which states are inside a frame
package loader_pkg;

  // Loader FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

  // Frame fields
  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam int         BYTES_PER_WORD = 4;
  localparam logic [1:0] LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);

  // True in the states where a framing error aborts the load attempt.
  // In IDLE a broken byte is simply noise on the line.
  function automatic logic in_frame(input logic [2:0] st);
    return (st == ST_COUNT) || (st == ST_DATA) || (st == ST_CHECK);
  endfunction

endpackage

// File: rtl/uart_rx.sv
// uart_rx
//   8N1 UART receiver with a 2-FF input synchronizer.
//   Ports:
//     clk, reset  system clock, async active-high reset
//     rxd         raw serial line (idle high, asynchronous to clk)
//     rx_valid    one-cycle strobe, rx_data holds a good byte
//     rx_data     received byte, LSB first on the line
//     rx_ferr     one-cycle strobe, stop bit was read as 0
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic          sync1, sync2, sync_prev;
  logic [1:0]    phase;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // Synchronizer, start detection and bit timing. sync_prev is the previous
  // synchronized sample, so a 1->0 step between them marks a start edge.
  // The start bit is re-sampled half a bit later to reject short glitches;
  // after that every sample lands one full bit period later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
      phase     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      rx_ferr   <= 1'b0;
    end else begin
      sync1     <= rxd;
      sync2     <= sync1;
      sync_prev <= sync2;
      rx_valid  <= 1'b0;
      rx_ferr   <= 1'b0;
      case (phase)
        RX_IDLE: begin
          if (sync_prev && !sync2) begin
            phase <= RX_START;
            cnt   <= '0;
          end
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            phase   <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            shreg <= {sync2, shreg[7:1]};
            if (bit_idx == 3'd7) phase <= RX_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (cnt == FULL) begin
            cnt   <= '0;
            phase <= RX_IDLE;
            if (sync2) begin
              rx_valid <= 1'b1;
              rx_data  <= shreg;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_loader.sv
// uart_loader
//   Receives a framed program image over UART and writes it word by word
//   into the core's memory, holding the core in reset until the image's
//   checksum matches.
//   Frame: A5, N, 4*N data bytes (little-endian words), XOR checksum.
//   Ports:
//     clk, reset  system clock, async active-high reset
//     rxd         raw UART line, idle high
//     mem_we      one-cycle write strobe
//     mem_addr    word address of the write
//     mem_wdata   write data
//     cpu_hold    high keeps the core in reset
//     load_done   sticky, image loaded with matching checksum
//     load_err    sticky, last attempt hit a framing or checksum error
module uart_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rxd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ferr;

  logic [2:0] state;
  logic [7:0] words_left;
  logic [1:0] byte_idx;
  logic [7:0] csum;
  logic       go_err;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rxd      (rxd),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ferr  (rx_ferr)
  );

  // An attempt fails on any broken byte inside a frame, or on a checksum
  // byte that does not match the running XOR.
  always_comb begin
    go_err = 1'b0;
    if (rx_ferr && in_frame(state))
      go_err = 1'b1;
    if (state == ST_CHECK && rx_valid && rx_data != csum)
      go_err = 1'b1;
  end

  // Framing FSM, word assembler, checksum and address counter.
  // mem_we is registered off the 4th byte's rx_valid, so address and data
  // are already settled while it is high; the address steps right after.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      words_left <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (mem_we)
        mem_addr <= mem_addr + ADDR_W'(1);

      if (go_err) begin
        state    <= ST_ERROR;
        load_err <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rx_valid && rx_data == SYNC_BYTE) begin
              state    <= ST_COUNT;
              load_err <= 1'b0;
            end
          end
          ST_COUNT: begin
            if (rx_valid) begin
              words_left <= rx_data;
              mem_addr   <= '0;
              byte_idx   <= '0;
              csum       <= '0;
              state      <= (rx_data == 8'd0) ? ST_CHECK : ST_DATA;
            end
          end
          ST_DATA: begin
            if (rx_valid) begin
              mem_wdata[{byte_idx, 3'b000} +: 8] <= rx_data;
              csum     <= csum ^ rx_data;
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == LAST_BYTE_IDX) begin
                mem_we     <= 1'b1;
                words_left <= words_left - 8'd1;
                if (words_left == 8'd1)
                  state <= ST_CHECK;
              end
            end
          end
          ST_CHECK: begin
            // A mismatch is handled by go_err above.
            if (rx_valid) begin
              state     <= ST_DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end
          end
          ST_ERROR: state <= ST_IDLE;
          default:  state <= ST_DONE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader
//   Self-checking bench for uart_loader. Frames are built in the bench, a
//   frame-level model predicts the memory writes and final status, the
//   writes go into a scoreboard queue and a monitor pops them on mem_we.
module tb_uart_loader;

  localparam int CPB = 8;
  localparam int AW  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          rxd;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t  expQ[$];
  logic mDone, mErr, mSyncErr;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: every write strobe must match the oldest prediction.
  always @(negedge clk) begin
    wr_t w;
    if (reset === 1'b0 && mem_we === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        $display("[TB] FAIL spurious write: got addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
      end else begin
        w = expQ.pop_front();
        checkOutput("write addr", 32'(mem_addr), 32'(w.addr));
        checkOutput("write data", mem_wdata, w.data);
      end
    end
  end

  task automatic checkReset(input string tag);
    checkOutput({tag, " mem_we"},    32'(mem_we),    32'd0);
    checkOutput({tag, " mem_addr"},  32'(mem_addr),  32'd0);
    checkOutput({tag, " mem_wdata"}, mem_wdata,      32'd0);
    checkOutput({tag, " cpu_hold"},  32'(cpu_hold),  32'd1);
    checkOutput({tag, " load_done"}, 32'(load_done), 32'd0);
    checkOutput({tag, " load_err"},  32'(load_err),  32'd0);
  endtask

  task automatic clearModel();
    expQ.delete();
    mDone = 1'b0;
    mErr  = 1'b0;
  endtask

  task automatic doReset();
    rxd   = 1'b1;
    reset = 1'b1;
    #2;
    checkReset("reset");
    repeat (2) @(negedge clk);
    clearModel();
    reset = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    @(posedge clk); #1;
    rxd = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rxd = stopBit;
    repeat (CPB) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  // Builds A5, N, words (little-endian), XOR checksum ^ corrupt.
  task automatic makeFrame(input logic [31:0] words[$], input logic [7:0] corrupt,
                           output logic [7:0] frame[$]);
    logic [7:0] x;
    x = 8'h00;
    frame.delete();
    frame.push_back(8'hA5);
    frame.push_back(8'(words.size()));
    foreach (words[i])
      for (int k = 0; k < 4; k++) begin
        frame.push_back(words[i][8*k +: 8]);
        x ^= words[i][8*k +: 8];
      end
    frame.push_back(x ^ corrupt);
  endtask

  // Frame-level reference: which whole words arrive before any broken byte,
  // and whether the checksum byte equals the XOR of all data bytes.
  task automatic modelFrame(input logic [7:0] frame[$], input int ferrAt);
    int         n, last;
    logic [7:0] x;
    wr_t        w;
    if (mDone) begin
      mSyncErr = mErr;
      return;
    end
    mSyncErr = 1'b0;
    mErr     = 1'b0;
    if (ferrAt == 1) begin
      mErr = 1'b1;
      return;
    end
    n    = int'(frame[1]);
    last = (ferrAt < 0) ? frame.size() : ferrAt;
    for (int wi = 0; wi < n; wi++)
      if (2 + 4 * wi + 3 < last) begin
        w.addr = AW'(wi);
        w.data = {frame[2+4*wi+3], frame[2+4*wi+2], frame[2+4*wi+1], frame[2+4*wi]};
        expQ.push_back(w);
      end
    if (ferrAt >= 0) begin
      mErr = 1'b1;
      return;
    end
    x = 8'h00;
    for (int i = 2; i < 2 + 4 * n; i++) x ^= frame[i];
    if (frame[2 + 4 * n] == x) mDone = 1'b1;
    else                       mErr  = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] frame[$], input int ferrAt);
    modelFrame(frame, ferrAt);
    foreach (frame[i]) begin
      if (i == ferrAt) begin
        sendByte(frame[i], 1'b0);
        break;
      end
      sendByte(frame[i], 1'b1);
      if (i == 0) checkOutput("load_err after sync", 32'(load_err), 32'(mSyncErr));
    end
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, " writes pending"}, 32'(expQ.size()), 32'd0);
    checkOutput({tag, " load_done"}, 32'(load_done), 32'(mDone));
    checkOutput({tag, " load_err"},  32'(load_err),  32'(mErr));
    checkOutput({tag, " cpu_hold"},  32'(cpu_hold),  32'(!mDone));
  endtask

  initial begin
    logic [31:0] words[$];
    logic [7:0]  frame[$];
    int          n, mode, ferrAt;
    logic [7:0]  corrupt;

    clearModel();
    doReset();

    // Nominal load, then bad checksum and retry
    words = '{32'h00000013, 32'h0000006F};
    makeFrame(words, 8'h00, frame);
    checkOutput("nominal checksum byte", 32'(frame[10]), 32'h7C);
    applyStimulus(frame, -1);
    checkStatus("nominal");

    doReset();
    makeFrame(words, 8'h7C, frame);
    applyStimulus(frame, -1);
    checkStatus("bad checksum");
    makeFrame(words, 8'h00, frame);
    applyStimulus(frame, -1);
    checkStatus("retry");

    // Once loaded, further frames are ignored
    words = '{32'hDEADBEEF};
    makeFrame(words, 8'h00, frame);
    applyStimulus(frame, -1);
    checkStatus("after done");

    // Framing error on the 3rd data byte, then garbage in IDLE
    doReset();
    words = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    makeFrame(words, 8'h00, frame);
    applyStimulus(frame, 4);
    checkStatus("ferr byte 3");
    words = '{32'h01020304, 32'h0A0B0C0D};
    makeFrame(words, 8'h00, frame);
    applyStimulus(frame, 9);
    checkStatus("ferr word 2");
    sendByte(8'h55, 1'b1);
    sendByte(8'hFF, 1'b1);
    checkStatus("garbage");

    // N = 0
    doReset();
    words.delete();
    makeFrame(words, 8'h00, frame);
    applyStimulus(frame, -1);
    checkStatus("n0 good");
    doReset();
    makeFrame(words, 8'h01, frame);
    applyStimulus(frame, -1);
    checkStatus("n0 bad");

    // Glitch: too short to survive the mid-start-bit re-check
    doReset();
    @(posedge clk); #1;
    rxd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (4 * CPB) @(posedge clk);
    checkStatus("glitch");
    words = '{32'hCAFEF00D};
    makeFrame(words, 8'h00, frame);
    applyStimulus(frame, -1);
    checkStatus("after glitch");

    // Reset in the middle of the 2nd data byte
    doReset();
    sendByte(8'hA5, 1'b1);
    sendByte(8'h02, 1'b1);
    sendByte(8'h13, 1'b1);
    checkOutput("partial word lane 0", mem_wdata, 32'h00000013);
    @(posedge clk); #1;
    rxd = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkReset("mid-frame reset");
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    clearModel();
    reset = 1'b0;
    repeat (4) @(posedge clk);
    words = '{32'h00000013, 32'h0000006F};
    makeFrame(words, 8'h00, frame);
    applyStimulus(frame, -1);
    checkStatus("after mid reset");

    // Randomized frames with a retry after any failure
    for (int it = 0; it < 6; it++) begin
      doReset();
      n = $urandom_range(0, 4);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back($urandom);
      mode    = $urandom_range(0, 2);
      corrupt = (mode == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
      makeFrame(words, corrupt, frame);
      ferrAt  = (mode == 2) ? $urandom_range(1, frame.size() - 1) : -1;
      applyStimulus(frame, ferrAt);
      checkStatus("random");
      if (!mDone) begin
        words.delete();
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) words.push_back($urandom);
        makeFrame(words, 8'h00, frame);
        applyStimulus(frame, -1);
        checkStatus("random retry");
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
